s2p_framer: RTL and testbench
=============================

# s2p_framer

Parametrised serial-to-parallel frame assembler for the 1-Wire slave datapath. It sits between the bit-level line decoder and the command/ROM layers. It accumulates FRAME_W received bits into a frame and hands the frame over through a valid/ack holding register. It adds bit-order selection, frame resync, overrun reporting and optional on-the-fly Dallas CRC-8 checking.

## Interface
- FRAME_W, 64, bits per frame; legal range 8..256.
- LSB_FIRST, 1, 1: first received bit lands in o_parallel[0]; 0: first received bit lands in o_parallel[FRAME_W-1].
- CNT_W (localparam), $clog2(FRAME_W), bit-counter width.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- i_bit_val  in  1  received bit value; sampled only when i_bit_ready=1.
- i_bit_ready  in  1  one-cycle strobe, one bit per strobe.
- i_frame_start  in  1  resync pulse that discards any partial frame.
- i_frame_ack  in  1  consumer accepts the held frame.
- o_parallel  out  FRAME_W  held frame; stable while o_frame_valid=1.
- o_frame_valid  out  1  held frame available; level signal until acked.
- o_overrun  out  1  one-cycle pulse when a completed frame is dropped.
- o_crc_ok  out  1  CRC result for the held frame; qualified by o_frame_valid.
- o_bit_count  out  CNT_W  bits accumulated in the current partial frame.

## Operation
- Reset values:
  - o_parallel=0, o_frame_valid=0, o_overrun=0, o_bit_count=0.
  - Shift register=0, CRC register=0.
  - o_crc_ok=0 with CRC compiled in; constant 1 without it.
- Assembly side states:
  - ACCUM: count 0..FRAME_W-1.
  - Each i_bit_ready strobe shifts i_bit_val in and increments the count.
  - LSB_FIRST=1: shift right, new bit enters at the MSB.
  - LSB_FIRST=0: shift left, new bit enters at the LSB.
- Frame completion: an i_bit_ready strobe while count==FRAME_W-1 completes the frame. On completion the count wraps to 0 and the CRC register clears.
- Output side states: EMPTY and FULL.
  - Completion while EMPTY, or while FULL with i_frame_ack=1 in the same cycle: load the assembled frame (including the current bit) into o_parallel; the state becomes FULL.
  - Completion while FULL with i_frame_ack=0: drop the new frame, keep o_parallel unchanged, pulse o_overrun.
  - i_frame_ack while FULL with no completion in the same cycle: go to EMPTY, o_frame_valid=0. o_parallel keeps its last value.
  - i_frame_ack while EMPTY is ignored.
- i_frame_start:
  - Clears the count and the CRC register. The output side is unaffected.
  - If i_bit_ready=1 in the same cycle, that bit becomes bit 0 of the new frame: count=1.
  - If i_frame_start arrives on the completing strobe, start wins: no frame is delivered and no overrun is reported.
- Shift register contents are not cleared on resync. They are only meaningful once FRAME_W strobes have occurred.

## Timing
- o_frame_valid, o_parallel and o_crc_ok update on the clk edge that samples the final strobe. They are visible the following cycle, so latency is 1 cycle.
- The minimum strobe spacing is 1 cycle; back-to-back i_bit_ready every cycle is supported.
- o_overrun is high for exactly one cycle per dropped frame.
- An asynchronous reset mid-frame or mid-hold returns every output to its reset value immediately. The partial frame is lost.

## Configuration
- S2P_CRC8_EN defined:
  - A serial Dallas CRC-8 (x^8+x^5+x^4+1, reflected 8'h8C, init 0x00) is advanced on every accepted bit.
  - On completion, o_crc_ok is registered as (crc_next==0). A frame with a valid trailing CRC byte (e.g. 1-Wire ROM code) therefore yields 1.
- S2P_CRC8_EN undefined: no CRC logic; o_crc_ok is tied to 1.

## Structure
- Package s2p_pkg holds:
  - Constant CRC8_POLY_REFL=8'h8C.
  - Function crc8_bit_step(crc, bit).
  - Enum out_state_t {OUT_EMPTY, OUT_FULL}.
- Sub-module crc8_serial contains the CRC register, clear, enable and step logic. It is instantiated only under S2P_CRC8_EN.

## Test plan
- FRAME_W=64, LSB_FIRST=1: send 64'h0123_4567_89AB_CDEF LSB-first with one strobe every 3 cycles -> one cycle after the 64th strobe, o_frame_valid=1 and o_parallel=64'h0123_4567_89AB_CDEF; it holds until ack.
- LSB_FIRST=0, FRAME_W=8: send bits 1,0,1,1,0,0,0,1 -> o_parallel=8'hB1.
- Two 64-bit frames without ack -> o_overrun pulses for 1 cycle at the second completion; o_parallel still equals frame 1. Then ack at the third completion -> frame 3 loaded, o_frame_valid stays 1, no overrun.
- Send 10 bits, pulse i_frame_start together with a strobe, then 63 more bits -> exactly one frame, built from the bits starting at the resync strobe. o_bit_count reads 1 after the resync.
- S2P_CRC8_EN: ROM code 64'hA200_0000_01B8_1C02 -> o_crc_ok=1. The same code with bit 5 flipped -> o_crc_ok=0.
- Assert reset after 30 bits, release, send a full frame -> all outputs 0 during reset. The first valid frame contains only the post-reset bits.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel frame assembler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package s2p_pkg;

  // Dallas/Maxim CRC-8 polynomial x^8+x^5+x^4+1, bit-reversed for LSB-first shifting
  localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;

  // Output-side holding register occupancy
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Advance a reflected CRC-8 by one received bit
  function automatic logic [7:0] crc8_bit_step(input logic [7:0] crc, input logic i_bit);
    logic fb;
    fb = crc[0] ^ i_bit;
    crc8_bit_step = {1'b0, crc[7:1]} ^ (fb ? CRC8_POLY_REFL : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Serial Dallas CRC-8 accumulator advanced once per accepted bit.
// Latency: o_crc_next is combinational from the current register and inputs.
// Backpressure: none; i_en qualifies each bit, i_clr/i_wrap restart the sum.
module crc8_serial
  import s2p_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  input  logic       i_wrap,
  output logic [7:0] o_crc_next
);

  logic [7:0] r_crc;
  logic [7:0] w_base;
  logic [7:0] w_next;

  // A resync in the same cycle as a bit restarts the sum before that bit is folded in
  always_comb begin
    w_base = i_clr ? 8'h00 : r_crc;
    w_next = i_en ? crc8_bit_step(w_base, i_bit) : w_base;
  end

  // Register the running sum; a completed frame starts the next one from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= 8'h00;
    end else begin
      r_crc <= i_wrap ? 8'h00 : w_next;
    end
  end

  assign o_crc_next = w_next;

endmodule

// File: rtl/s2p_framer.sv
// Serial-to-parallel frame assembler with resync, overrun pulse and optional CRC-8 (S2P_CRC8_EN).
// Latency: frame and o_frame_valid visible 1 cycle after the final bit strobe.
// Backpressure: single holding register; a frame completing while one is held un-acked is dropped with o_overrun.
module s2p_framer
  import s2p_pkg::*;
#(
  parameter  int FRAME_W   = 64,
  parameter  bit LSB_FIRST = 1'b1,
  localparam int CNT_W     = $clog2(FRAME_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_bit_val,
  input  logic               i_bit_ready,
  input  logic               i_frame_start,
  input  logic               i_frame_ack,
  output logic [FRAME_W-1:0] o_parallel,
  output logic               o_frame_valid,
  output logic               o_overrun,
  output logic               o_crc_ok,
  output logic [CNT_W-1:0]   o_bit_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

  out_state_t         r_state;
  out_state_t         w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] w_shift_next;
  logic [FRAME_W-1:0] r_parallel;
  logic               r_overrun;
  logic               w_complete;
  logic               w_load;
  logic               w_drop;

  // A resync on the final strobe abandons that frame, so it never completes
  assign w_complete = i_bit_ready && !i_frame_start && (r_count == LAST_IDX);

  // Next bit count: resync restarts at 0 (or 1 if a bit arrives with it), completion wraps
  always_comb begin
    w_count_next = r_count;
    if (i_frame_start) begin
      w_count_next = i_bit_ready ? CNT_W'(1) : '0;
    end else if (i_bit_ready) begin
      w_count_next = (r_count == LAST_IDX) ? '0 : r_count + CNT_W'(1);
    end
  end

  // Shift direction chosen so the first bit of a frame ends up at the selected end
  always_comb begin
    if (LSB_FIRST) begin
      w_shift_next = {i_bit_val, r_shift[FRAME_W-1:1]};
    end else begin
      w_shift_next = {r_shift[FRAME_W-2:0], i_bit_val};
    end
  end

  // Assembly registers; shift contents survive resync and only become meaningful after a full frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_shift <= '0;
    end else begin
      r_count <= w_count_next;
      if (i_bit_ready) begin
        r_shift <= w_shift_next;
      end
    end
  end

  // Output-side state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Holding register control: an ack in the completing cycle frees the slot for the new frame
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      OUT_EMPTY: begin
        if (w_complete) begin
          w_load       = 1'b1;
          w_state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (w_complete) begin
          if (i_frame_ack) begin
            w_load = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else if (i_frame_ack) begin
          w_state_next = OUT_EMPTY;
        end
      end
      default: begin
        w_state_next = OUT_EMPTY;
      end
    endcase
  end

  // Capture the frame including the completing bit; overrun is a single-cycle pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parallel <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_load) begin
        r_parallel <= w_shift_next;
      end
    end
  end

`ifdef S2P_CRC8_EN
  logic [7:0] w_crc_next;
  logic       r_crc_ok;

  crc8_serial u_crc8 (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (i_frame_start),
    .i_en       (i_bit_ready),
    .i_bit      (i_bit_val),
    .i_wrap     (w_complete),
    .o_crc_next (w_crc_next)
  );

  // A frame carrying its own trailing CRC byte leaves a zero residue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc_ok <= 1'b0;
    end else if (w_load) begin
      r_crc_ok <= (w_crc_next == 8'h00);
    end
  end

  assign o_crc_ok = r_crc_ok;
`else
  assign o_crc_ok = 1'b1;
`endif

  assign o_parallel    = r_parallel;
  assign o_frame_valid = (r_state == OUT_FULL);
  assign o_overrun     = r_overrun;
  assign o_bit_count   = r_count;

endmodule

// File: tb/tb_s2p_framer.sv
// Bench for s2p_framer: a 64-bit LSB-first instance and an 8-bit MSB-first instance.
// A frame-level model (bit lists per frame) is checked against both DUTs every cycle.
// Directed scenarios pin the model with literal expectations, then random traffic runs.
module tb_s2p_framer;

`ifdef S2P_CRC8_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] rdy, val, st, ack;

  logic [63:0] par0;
  logic [7:0]  par1;
  logic        vld0, vld1, ov0, ov1, crc0, crc1;
  logic [5:0]  cnt0;
  logic [2:0]  cnt1;

  s2p_framer #(.FRAME_W(64), .LSB_FIRST(1'b1)) dut64 (
    .clk(clk), .reset(reset), .i_bit_val(val[0]), .i_bit_ready(rdy[0]),
    .i_frame_start(st[0]), .i_frame_ack(ack[0]), .o_parallel(par0),
    .o_frame_valid(vld0), .o_overrun(ov0), .o_crc_ok(crc0), .o_bit_count(cnt0)
  );

  s2p_framer #(.FRAME_W(8), .LSB_FIRST(1'b0)) dut8 (
    .clk(clk), .reset(reset), .i_bit_val(val[1]), .i_bit_ready(rdy[1]),
    .i_frame_start(st[1]), .i_frame_ack(ack[1]), .o_parallel(par1),
    .o_frame_valid(vld1), .o_overrun(ov1), .o_crc_ok(crc1), .o_bit_count(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ov_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mbits [2][64];
  int          mcnt  [2];
  logic [63:0] mpar  [2];
  bit          mvalid[2];
  bit          mov   [2];
  bit          mcrc  [2];

  function automatic int width_of(input int d);
    return (d == 0) ? 64 : 8;
  endfunction

  // Place received bit i at index i (LSB-first) or at index W-1-i (MSB-first)
  function automatic logic [63:0] assemble(input int d);
    logic [63:0] f;
    int w;
    f = '0;
    w = width_of(d);
    for (int i = 0; i < w; i++) begin
      if (d == 0) f[i] = mbits[d][i];
      else        f[w-1-i] = mbits[d][i];
    end
    return f;
  endfunction

  // Dallas CRC-8 over the frame's bit list in arrival order; residue 0 means good
  function automatic bit crc_good(input int d);
    logic [7:0] c;
    bit fb;
    c = 8'h00;
    for (int i = 0; i < width_of(d); i++) begin
      fb = c[0] ^ mbits[d][i];
      c = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return (c == 8'h00);
  endfunction

  task automatic model_step(input int d);
    bit done;
    done = 1'b0;
    mov[d] = 1'b0;
    if (st[d]) mcnt[d] = 0;
    if (rdy[d]) begin
      mbits[d][mcnt[d]] = val[d];
      mcnt[d]++;
      if (mcnt[d] == width_of(d)) begin
        done = 1'b1;
        mcnt[d] = 0;
      end
    end
    if (done) begin
      if (!mvalid[d] || ack[d]) begin
        mpar[d]   = assemble(d);
        mcrc[d]   = CRC_EN ? crc_good(d) : 1'b1;
        mvalid[d] = 1'b1;
      end else begin
        mov[d] = 1'b1;
      end
    end else if (ack[d] && mvalid[d]) begin
      mvalid[d] = 1'b0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        mcnt[d] = 0; mpar[d] = '0; mvalid[d] = 1'b0; mov[d] = 1'b0;
        mcrc[d] = CRC_EN ? 1'b0 : 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // Every-cycle comparison of all outputs of both instances against the model
  always @(negedge clk) begin
    chk("valid64",    64'(vld0), 64'(mvalid[0]));
    chk("count64",    64'(cnt0), 64'(mcnt[0]));
    chk("overrun64",  64'(ov0),  64'(mov[0]));
    chk("parallel64", par0,      mpar[0]);
    chk("crc_ok64",   64'(crc0), 64'(mcrc[0]));
    chk("valid8",     64'(vld1), 64'(mvalid[1]));
    chk("count8",     64'(cnt1), 64'(mcnt[1]));
    chk("overrun8",   64'(ov1),  64'(mov[1]));
    chk("parallel8",  64'(par1), mpar[1]);
    chk("crc_ok8",    64'(crc1), 64'(mcrc[1]));
    if (ov0) ov_pulses++;
  end

  // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
  task automatic strobe(input int d, input bit b, input bit s, input bit a, input int gap);
    rdy[d] = 1'b1; val[d] = b; st[d] = s; ack[d] = a;
    @(posedge clk); #1;
    rdy[d] = 1'b0; st[d] = 1'b0; ack[d] = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int d, input logic [63:0] f, input int gap, input bit ack_last);
    int w;
    bit b;
    w = width_of(d);
    for (int i = 0; i < w; i++) begin
      b = (d == 0) ? f[i] : f[w-1-i];
      strobe(d, b, 1'b0, (i == w-1) ? ack_last : 1'b0, (i == w-1) ? 0 : gap);
    end
  endtask

  task automatic pulse_ack(input int d);
    ack[d] = 1'b1;
    @(posedge clk); #1;
    ack[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [63:0] fa, fb_, fc, fr, fg, rom;
  logic [7:0]  seq8;
  int          ov_before;

  initial begin
    reset = 1'b1;
    rdy = '0; val = '0; st = '0; ack = '0;
    idle(3);
    chk("reset_valid", 64'(vld0), 64'd0);
    chk("reset_par",   par0, 64'd0);
    chk("reset_crc",   64'(crc0), CRC_EN ? 64'd0 : 64'd1);
    reset = 1'b0;
    idle(2);

    // LSB-first 64-bit frame, one strobe every 3 cycles
    send_frame(0, 64'h0123_4567_89AB_CDEF, 2, 1'b0);
    chk("t1_valid", 64'(vld0), 64'd1);
    chk("t1_par",   par0, 64'h0123_4567_89AB_CDEF);
    chk("t1_model", mpar[0], 64'h0123_4567_89AB_CDEF);
    idle(5);
    chk("t1_hold",  par0, 64'h0123_4567_89AB_CDEF);
    pulse_ack(0);
    chk("t1_acked", 64'(vld0), 64'd0);

    // MSB-first 8-bit frame: bits 1,0,1,1,0,0,0,1
    seq8 = 8'b1011_0001;
    for (int i = 0; i < 8; i++) strobe(1, seq8[7-i], 1'b0, 1'b0, 1);
    chk("t2_par8",   64'(par1), 64'hB1);
    chk("t2_model8", mpar[1], 64'hB1);
    pulse_ack(1);

    // Overrun: two frames without ack, then a third acked on its final strobe
    fa = {$urandom, $urandom}; fb_ = {$urandom, $urandom}; fc = {$urandom, $urandom};
    ov_before = ov_pulses;
    send_frame(0, fa, 0, 1'b0);
    send_frame(0, fb_, 0, 1'b0);
    idle(2);
    chk("t3_overrun_cnt", 64'(ov_pulses - ov_before), 64'd1);
    chk("t3_par_is_a",    par0, fa);
    send_frame(0, fc, 1, 1'b1);
    chk("t3_par_is_c",    par0, fc);
    chk("t3_valid",       64'(vld0), 64'd1);
    idle(2);
    chk("t3_no_overrun",  64'(ov_pulses - ov_before), 64'd1);
    pulse_ack(0);

    // Resync: 10 junk bits, then a start together with bit 0 of the real frame
    fr = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) strobe(0, 1'($urandom), 1'b0, 1'b0, 0);
    strobe(0, fr[0], 1'b1, 1'b0, 0);
    chk("t4_count1", 64'(cnt0), 64'd1);
    for (int i = 1; i < 64; i++) strobe(0, fr[i], 1'b0, 1'b0, 0);
    chk("t4_valid", 64'(vld0), 64'd1);
    chk("t4_par",   par0, fr);
    pulse_ack(0);

    // CRC: valid ROM code, then the same code with bit 5 flipped
    rom = 64'hA200_0000_01B8_1C02;
    send_frame(0, rom, 0, 1'b0);
    chk("t5_crc_good", 64'(crc0), 64'd1);
    chk("t5_model_good", 64'(mcrc[0]), 64'd1);
    pulse_ack(0);
    rom[5] = ~rom[5];
    send_frame(0, rom, 0, 1'b0);
    chk("t5_crc_bad", 64'(crc0), CRC_EN ? 64'd0 : 64'd1);
    pulse_ack(0);

    // Reset while holding a frame and mid-way through the next one
    send_frame(0, {$urandom, $urandom}, 0, 1'b0);
    for (int i = 0; i < 30; i++) strobe(0, 1'($urandom), 1'b0, 1'b0, 0);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(vld0), 64'd0);
    chk("t6_rst_par",   par0, 64'd0);
    chk("t6_rst_count", 64'(cnt0), 64'd0);
    chk("t6_rst_crc",   64'(crc0), CRC_EN ? 64'd0 : 64'd1);
    idle(2);
    reset = 1'b0;
    idle(1);
    fg = {$urandom, $urandom};
    send_frame(0, fg, 0, 1'b0);
    chk("t6_par_post", par0, fg);
    chk("t6_valid",    64'(vld0), 64'd1);
    pulse_ack(0);

    // Random traffic on both instances, back-to-back strobes included
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < 2; d++) begin
        rdy[d] = ($urandom % 4) != 0;
        val[d] = 1'($urandom);
        st[d]  = ($urandom % 60) == 0;
        ack[d] = ($urandom % 5) == 0;
      end
      @(posedge clk); #1;
    end
    rdy = '0; st = '0; ack = '0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
